// File: rtl/keystream_xor.sv
// keystream_xor
//   Builds a W-bit keystream word from K = W/N consecutive N-bit words of an
//   upstream LFSR, then XORs one plaintext word with it. Each accepted word
//   consumes a fresh keystream, so the block alternates between FILL (pull K
//   LFSR words) and ARMED (wait for a plaintext word).
//
//   Optional build macro: KEYSTREAM_XOR_DBG_KS_EN adds output ks_dbg, a copy
//   of the keystream register for trace correlation.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   lfsr_ena   out  1   advance request to the LFSR (high in FILL)
//   lfsr_word  in   N   current LFSR output word
//   in_data    in   W   plaintext
//   in_valid   in   1   plaintext present
//   in_ready   out  1   plaintext accepted this cycle
//   out_data   out  W   ciphertext
//   out_valid  out  1   ciphertext present
//   out_ready  in   1   consumer accepts ciphertext
//   word_cnt   out  16  words accepted since reset (wraps)
//   busy       out  1   high while filling the keystream
//   ks_dbg     out  W   keystream register (only with KEYSTREAM_XOR_DBG_KS_EN)
module keystream_xor #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic         lfsr_ena,
  input  logic [N-1:0] lfsr_word,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  word_cnt,
  output logic         busy
`ifdef KEYSTREAM_XOR_DBG_KS_EN
  ,
  output logic [W-1:0] ks_dbg
`endif
);

  localparam int K  = W / N;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  if ((W % N) != 0 || W < N) begin : g_bad_width
    $error("keystream_xor: W must be a non-zero multiple of N");
  end

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_ks;
  logic          w_fill_done;
  logic          w_xfer;

  assign lfsr_ena    = (r_state == S_FILL);
  assign busy        = lfsr_ena;
  // A slot opens when the output register is empty or being drained now,
  // which lets drain and reload happen on the same edge.
  assign in_ready    = (r_state == S_ARMED) && (!out_valid || out_ready);
  assign w_xfer      = in_valid && in_ready;
  assign w_fill_done = (r_state == S_FILL) && (r_k == KW'(K - 1));

`ifdef KEYSTREAM_XOR_DBG_KS_EN
  assign ks_dbg = r_ks;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_fill_done) w_state_nxt = S_ARMED;
      S_ARMED: if (w_xfer)      w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Keystream assembly: shift left so the first sampled LFSR word ends up
  // in the MSBs after K cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k  <= '0;
      r_ks <= '0;
    end else if (r_state == S_FILL) begin
      r_ks <= (r_ks << N) | W'(lfsr_word);
      r_k  <= w_fill_done ? '0 : r_k + KW'(1);
    end
  end

  // Output register and accepted-word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else if (w_xfer) begin
      out_data  <= in_data ^ r_ks;
      out_valid <= 1'b1;
      word_cnt  <= word_cnt + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keystream_xor.sv
// Directed bench for keystream_xor (N=4, W=8). The LFSR is modelled as a
// fixed word list whose index advances on every clock with lfsr_ena high
// while out of reset. List: 0x1, 0x8, then (i*5+3) mod 16.
module tb_keystream_xor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lfsr_ena;
  logic [3:0] lfsr_word;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [15:0] word_cnt;
  logic       busy;
`ifdef KEYSTREAM_XOR_DBG_KS_EN
  logic [7:0] ks_dbg;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int idx   = 0;

  keystream_xor #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .lfsr_ena  (lfsr_ena),
    .lfsr_word (lfsr_word),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt),
    .busy      (busy)
`ifdef KEYSTREAM_XOR_DBG_KS_EN
    ,
    .ks_dbg    (ks_dbg)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] wl(input int i);
    if (i == 0) return 4'h1;
    if (i == 1) return 4'h8;
    return 4'((i * 5 + 3) & 15);
  endfunction

  assign lfsr_word = wl(idx);

  always @(posedge clk) begin
    if (rst && lfsr_ena) idx <= idx + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %0h want 1", busy); end
    n_cmp++; if (lfsr_ena !== 1'b1) begin n_bad++; $display("FAIL rst_lfsr_ena: got %0h want 1", lfsr_ena); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0h want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0h want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %0h want 00", out_data); end
    n_cmp++; if (word_cnt !== 16'h0000) begin n_bad++; $display("FAIL rst_word_cnt: got %0h want 0000", word_cnt); end
  endtask

  // First word: keystream {1,8} = 0x18, 0xA5 ^ 0x18 = 0xBD.
  task automatic test_first_word();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fw_ready_c1: got %0h want 0", in_ready); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fw_busy_c2: got %0h want 1", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fw_ready_c2: got %0h want 0", in_ready); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fw_busy_c3: got %0h want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fw_ready_c3: got %0h want 1", in_ready); end
`ifdef KEYSTREAM_XOR_DBG_KS_EN
    n_cmp++; if (ks_dbg !== 8'h18) begin n_bad++; $display("FAIL fw_ks_dbg: got %0h want 18", ks_dbg); end
`endif
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fw_out_valid: got %0h want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hBD) begin n_bad++; $display("FAIL fw_out_data: got %0h want BD", out_data); end
    n_cmp++; if (word_cnt !== 16'd1) begin n_bad++; $display("FAIL fw_word_cnt: got %0h want 1", word_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fw_busy_refill: got %0h want 1", busy); end
  endtask

  // Second keystream {D,2} = 0xD2; 0x3C ^ 0xD2 = 0xEE.
  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_a: got %0h want 0", in_ready); end
    n_cmp++; if (out_data !== 8'hBD) begin n_bad++; $display("FAIL bp_hold_a: got %0h want BD", out_data); end
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_b: got %0h want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_b: got %0h want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hBD) begin n_bad++; $display("FAIL bp_hold_b: got %0h want BD", out_data); end
    n_cmp++; if (word_cnt !== 16'd1) begin n_bad++; $display("FAIL bp_cnt_b: got %0h want 1", word_cnt); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_open: got %0h want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_no_gap: got %0h want 1", out_valid); end
    n_cmp++; if (out_data !== 8'hEE) begin n_bad++; $display("FAIL bp_out_data: got %0h want EE", out_data); end
    n_cmp++; if (word_cnt !== 16'd2) begin n_bad++; $display("FAIL bp_word_cnt: got %0h want 2", word_cnt); end
  endtask

  // Third keystream {7,C} = 0x7C, held across 10 idle ARMED cycles.
  task automatic test_armed_hold();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hd_drain: got %0h want 0", out_valid); end
    n_cmp++; if (out_data !== 8'hEE) begin n_bad++; $display("FAIL hd_data_hold: got %0h want EE", out_data); end
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (lfsr_ena !== 1'b0) begin n_bad++; $display("FAIL hd_lfsr_ena_%0d: got %0h want 0", i, lfsr_ena); end
    end
`ifdef KEYSTREAM_XOR_DBG_KS_EN
    n_cmp++; if (ks_dbg !== 8'h7C) begin n_bad++; $display("FAIL hd_ks_dbg: got %0h want 7C", ks_dbg); end
`endif
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    n_cmp++; if (out_data !== 8'h7C) begin n_bad++; $display("FAIL hd_out_data: got %0h want 7C", out_data); end
    n_cmp++; if (word_cnt !== 16'd3) begin n_bad++; $display("FAIL hd_word_cnt: got %0h want 3", word_cnt); end
  endtask

  // Reset at k=1 with out_valid pending; refill takes words 7,8 = {6,B}.
  task automatic test_reset_mid_fill();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_out_valid: got %0h want 0", out_valid); end
    n_cmp++; if (word_cnt !== 16'd0) begin n_bad++; $display("FAIL mr_word_cnt: got %0h want 0", word_cnt); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL mr_out_data: got %0h want 00", out_data); end
    tick();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mr_ready_k1: got %0h want 0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mr_ready_armed: got %0h want 1", in_ready); end
    tick();
    n_cmp++; if (out_data !== 8'h94) begin n_bad++; $display("FAIL mr_out_data2: got %0h want 94", out_data); end
    n_cmp++; if (word_cnt !== 16'd1) begin n_bad++; $display("FAIL mr_word_cnt2: got %0h want 1", word_cnt); end
  endtask

  // 65537 back-to-back words from a fresh reset; LFSR list resumes at index 9.
  task automatic test_stream_wrap();
    int         base;
    logic [7:0] pt;
    logic [7:0] ks_exp;
    rst = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    base = 9;
    for (int i = 0; i < 65537; i++) begin
      pt      = 8'(i) ^ 8'h5A;
      in_data = pt;
      ks_exp  = {wl(base), wl(base + 1)};
      base    = base + 2;
      tick(); tick(); tick();
      n_cmp++;
      if (out_data !== (pt ^ ks_exp)) begin
        n_bad++;
        $display("FAIL st_word_%0d: got %0h want %0h", i, out_data, pt ^ ks_exp);
      end
    end
    n_cmp++; if (word_cnt !== 16'h0001) begin n_bad++; $display("FAIL st_wrap_cnt: got %0h want 0001", word_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_backpressure();
    test_armed_hold();
    test_reset_mid_fill();
    test_stream_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keystream_xor.md
KEYSTREAM_XOR -- requirements
Module: keystream_xor

Interface
REQ-001 Parameter N, default 4: LFSR word width; equals the n of the upstream LFSR stage.
REQ-002 Parameter W, default 8: plaintext/ciphertext width; W SHALL be a multiple of N, else elaboration fails; K = W/N.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 lfsr_ena  output  1  advance request driven to the LFSR stage's ena.
REQ-006 lfsr_word  input  N  current LFSR state (the LFSR random output).
REQ-007 in_data  input  W  plaintext word.
REQ-008 in_valid  input  1  plaintext present.
REQ-009 in_ready  output  1  block accepts plaintext this cycle.
REQ-010 out_data  output  W  ciphertext word.
REQ-011 out_valid  output  1  ciphertext present.
REQ-012 out_ready  input  1  consumer accepts ciphertext.
REQ-013 word_cnt  output  16  count of words accepted since reset.
REQ-014 busy  output  1  high in FILL state.

Function
REQ-015 FSM states FILL and ARMED; lfsr_ena = (state==FILL), combinational; busy = lfsr_ena.
REQ-016 In FILL, every cycle: ks <= {ks[W-N-1:0], lfsr_word}, first-sampled word ends in the MSBs; fill counter k increments 0..K-1.
REQ-017 FILL -> ARMED on the edge where k==K-1; k returns to 0; FILL lasts exactly K cycles.
REQ-018 in_ready = (state==ARMED) && (!out_valid || out_ready); in_ready SHALL be 0 in FILL.
REQ-019 Transfer occurs on an edge with in_valid && in_ready: out_data <= in_data ^ ks, out_valid <= 1, word_cnt += 1, state -> FILL.
REQ-020 ARMED holds ks and state indefinitely while no transfer; lfsr_ena stays 0 there (the LFSR does not advance).
REQ-021 Output drain: out_valid && out_ready with no simultaneous transfer -> out_valid <= 0; out_data holds its value.
REQ-022 Simultaneous drain and transfer in one cycle: new word loaded, out_valid stays 1, no bubble.
REQ-023 While out_valid && !out_ready: out_data and out_valid stable; no new word accepted.
REQ-024 Peak throughput: one word per K+1 cycles; latency from transfer edge to out_valid = 1 cycle.
REQ-025 word_cnt wraps 0xFFFF -> 0x0000 and does not saturate.
REQ-026 in_valid without in_ready: no state change; in_data not required to be held stable by this block.

Reset
REQ-027 While rst is 0, asynchronously: state=FILL, k=0, ks=0, out_data=0, out_valid=0, word_cnt=0.
REQ-028 During reset: in_ready=0, busy=1, and lfsr_ena=1; this is harmless because the LFSR shares rst.
REQ-029 Reset mid-FILL or with out_valid pending: the partial keystream and the pending ciphertext are discarded; the first post-reset fill restarts at k=0.

Configuration
REQ-030 Macro KEYSTREAM_XOR_DBG_KS_EN defined: extra output ks_dbg [W-1:0] equal to the ks register, for side-channel/trace correlation.
REQ-031 Macro undefined: port ks_dbg is absent and the function is otherwise identical.

Verification (N=4, W=8; the bench models the LFSR as a word list advanced on lfsr_ena)
REQ-032 Release reset; LFSR words 0x1, 0x8; in_valid=1, in_data=0xA5, out_ready=1 -> busy high for 2 cycles, in_ready high in cycle 3, out_data=0xBD with out_valid 1 cycle later, word_cnt=1.
REQ-033 out_ready=0 after the first word; second plaintext 0x3C offered -> in_ready stays 0, out_data holds 0xBD; raise out_ready -> in the same cycle the drain and the new transfer occur with no gap in out_valid.
REQ-034 In ARMED with in_valid=0 for 10 cycles -> lfsr_ena=0 and ks unchanged; a later word XORs with the same ks.
REQ-035 Assert rst mid-FILL (k=1) with out_valid=1 -> out_valid=0, word_cnt=0, and the next fill samples 2 fresh words.
REQ-036 Stream 65537 words -> word_cnt reads 0x0001; every out_data equals plaintext XOR the reference keystream.
REQ-037 Elaborate with N=3, W=8 -> elaboration error; with KEYSTREAM_XOR_DBG_KS_EN defined, ks_dbg equals 0x18 after the fill in REQ-032.
